// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative RV32M multiply/divide: one radix-2 shift-add or
// restoring-divide step per cycle on operand magnitudes, sign fixed up at the end.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic [4:0]      RdMDE
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;  // multiplicand or divisor magnitude
  logic [2:0]  f3_q;
  logic        neg_q;
  logic [4:0]  rd_q;

  logic        sgn_a, sgn_b, sa, sb, div0, ovf, special;
  logic [31:0] a_mag, b_mag, special_res;
  logic [32:0] mul_sum, div_t;
  logic [63:0] mul_nxt, div_nxt, step_nxt, prod_s;
  logic [31:0] q_mag, r_mag, fin;

  always_comb begin
    sgn_a = Funct3E[2] ? ~Funct3E[0] : (Funct3E[1:0] != 2'b11);
    sgn_b = Funct3E[2] ? ~Funct3E[0] : ~Funct3E[1];
    sa    = sgn_a & SrcAE[31];
    sb    = sgn_b & SrcBE[31];
    a_mag = sa ? -SrcAE : SrcAE;
    b_mag = sb ? -SrcBE : SrcBE;
    div0  = (SrcBE == 32'd0);
    ovf   = ~Funct3E[0] && (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
    special = Funct3E[2] & (div0 | ovf);
    if (div0) special_res = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
    else      special_res = Funct3E[1] ? 32'd0 : 32'h8000_0000;

    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_nxt  = {mul_sum, acc[31:1]};
    // Trial subtract of the shifted partial remainder; borrow means restore.
    div_t    = acc[63:31] - {1'b0, opnd};
    div_nxt  = div_t[32] ? {acc[62:0], 1'b0} : {div_t[31:0], acc[30:0], 1'b1};
    step_nxt = f3_q[2] ? div_nxt : mul_nxt;

    prod_s = neg_q ? -step_nxt : step_nxt;
    q_mag  = step_nxt[31:0];
    r_mag  = step_nxt[63:32];
    if (f3_q[2])              fin = f3_q[1] ? (neg_q ? -r_mag : r_mag) : (neg_q ? -q_mag : q_mag);
    else if (f3_q[1:0] == 0)  fin = prod_s[31:0];
    else                      fin = prod_s[63:32];
  end

  assign BusyE = ~reset & (((state == IDLE) & StartE & ~FlushE) | (state == RUN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      rd_q    <= '0;
      DoneE   <= 1'b0;
      ResultE <= '0;
      RdMDE   <= '0;
    end else if (FlushE) begin
      state <= IDLE;
      cnt   <= '0;
      DoneE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DoneE <= 1'b0;
          if (StartE) begin
            f3_q  <= Funct3E;
            rd_q  <= RdE;
            cnt   <= '0;
            neg_q <= (Funct3E[2] & Funct3E[1]) ? sa : (sa ^ sb);
            opnd  <= Funct3E[2] ? b_mag : a_mag;
            acc   <= Funct3E[2] ? {32'd0, a_mag} : {32'd0, b_mag};
            if (special) begin
              state   <= DONE;
              DoneE   <= 1'b1;
              ResultE <= special_res;
              RdMDE   <= RdE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= step_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state   <= DONE;
            DoneE   <= 1'b1;
            ResultE <= fin;
            RdMDE   <= rd_q;
          end
        end
        DONE: begin
          // StartE is still the same instruction here; never restart from DONE.
          state <= IDLE;
          DoneE <= 1'b0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed RV32M results, latency,
// flush abort, async reset and no-retrigger from DONE.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, FlushE, StartE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE, SrcBE, ResultE;
  logic [4:0]  RdE, RdMDE;
  logic        BusyE, DoneE;

  int errors = 0;
  int checks = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StartE(StartE),
    .Funct3E(Funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE), .RdMDE(RdMDE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start an op at a falling edge, hold StartE like a stalled pipeline until
  // DoneE, then drop it and confirm the unit does not restart.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input int exp_lat, input logic [31:0] exp_res);
    int n, busy;
    @(negedge clk);
    Funct3E = f3; SrcAE = a; SrcBE = b; RdE = rd; StartE = 1'b1;
    #1;
    n = 0; busy = 0;
    while (!DoneE && n < 40) begin
      if (BusyE) busy++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_cycles"}, busy, exp_lat);
    check({tag, " result"}, ResultE, exp_res);
    check({tag, " rd"}, RdMDE, rd);
    check({tag, " busy_in_done"}, BusyE, 1'b0);
    @(posedge clk);
    #1 StartE = 1'b0;
    @(negedge clk);
    check({tag, " no_retrigger_busy"}, BusyE, 1'b0);
    check({tag, " no_retrigger_done"}, DoneE, 1'b0);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; FlushE = 1'b0; StartE = 1'b0; Funct3E = 3'd0;
    SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (2) @(negedge clk);
    check("reset busy", BusyE, 1'b0);
    check("reset done", DoneE, 1'b0);
    check("reset result", ResultE, 32'd0);
    check("reset rd", RdMDE, 5'd0);
    reset = 1'b0;

    run_op("mul 7*-3",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  33, 32'hFFFF_FFEB);
    run_op("mulhu",        3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  33, 32'hFFFF_FFFE);
    run_op("mulh",         3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  33, 32'h0000_0000);
    run_op("mulhsu",       3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  33, 32'hFFFF_FFFF);
    run_op("div -7/2",     3'b100, 32'hFFFF_FFF9, 32'd2,          5'd9,  33, 32'hFFFF_FFFD);
    run_op("rem -7/2",     3'b110, 32'hFFFF_FFF9, 32'd2,          5'd10, 33, 32'hFFFF_FFFF);
    run_op("divu 100/7",   3'b101, 32'd100,        32'd7,          5'd11, 33, 32'd14);
    run_op("remu 100/7",   3'b111, 32'd100,        32'd7,          5'd12, 33, 32'd2);
    run_op("div 5/0",      3'b100, 32'd5,          32'd0,          5'd13, 1,  32'hFFFF_FFFF);
    run_op("rem 5/0",      3'b110, 32'd5,          32'd0,          5'd14, 1,  32'd5);
    run_op("div ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1,  32'h8000_0000);
    run_op("rem ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1,  32'd0);

    // Flush at RUN count 10 (11th cycle after the start cycle).
    @(negedge clk);
    Funct3E = 3'b000; SrcAE = 32'd9; SrcBE = 32'd9; RdE = 5'd3; StartE = 1'b1;
    seen_done = 0;
    repeat (11) begin
      @(negedge clk);
      if (DoneE) seen_done++;
    end
    FlushE = 1'b1; StartE = 1'b0;
    #1 check("flush busy_before", BusyE, 1'b1);
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    check("flush busy_after", BusyE, 1'b0);
    if (DoneE) seen_done++;
    repeat (3) begin
      @(negedge clk);
      if (DoneE) seen_done++;
    end
    check("flush no_done", seen_done, 0);
    run_op("mul 3*4", 3'b000, 32'd3, 32'd4, 5'd17, 33, 32'd12);

    // Async reset between edges in the middle of RUN.
    @(negedge clk);
    Funct3E = 3'b101; SrcAE = 32'd50; SrcBE = 32'd3; RdE = 5'd20; StartE = 1'b1;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1; StartE = 1'b0;
    #1;
    check("async_rst busy", BusyE, 1'b0);
    check("async_rst done", DoneE, 1'b0);
    check("async_rst result", ResultE, 32'd0);
    check("async_rst rd", RdMDE, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("divu 50/3 after rst", 3'b101, 32'd50, 32'd3, 5'd21, 33, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Purpose: Execute-stage iterative multiply/divide unit (RV32M). It consumes the operands, destination index and funct3 registered by the D/E pipeline register. It stalls the pipeline through the hazard unit until its result is ready.

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 FlushE  input  1  synchronous abort of the in-flight operation (from hazard unit).
REQ-005 StartE  input  1  the instruction in Execute is an M-extension op (MulDivE control from D/E register).
REQ-006 Funct3E  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SrcAE  input  32  rs1 operand (post-forwarding).
REQ-008 SrcBE  input  32  rs2 operand (post-forwarding).
REQ-009 RdE  input  5  destination register index.
REQ-010 BusyE  output  1  stall request to hazard unit (holds F, D, D/E).
REQ-011 DoneE  output  1  one-cycle pulse; ResultE valid.
REQ-012 ResultE  output  32  operation result, valid only while DoneE=1.
REQ-013 RdMDE  output  5  destination index captured at start, valid with DoneE.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE with StartE=1 and FlushE=0: capture operands, Funct3E and RdE on the edge, then go to RUN. Special cases go directly to DONE.
REQ-016 BusyE = (IDLE and StartE and not FlushE) or RUN, combinational. BusyE = 0 in DONE.
REQ-017 RUN: one radix-2 step per cycle; a 6-bit counter runs 0..31; at count 31 go to DONE.
REQ-018 Normal latency: start edge + 32 RUN cycles. DoneE is high in the 33rd cycle after the start cycle.
REQ-019 DONE: DoneE=1 for exactly one cycle; ResultE and RdMDE are stable; next state is IDLE unconditionally.
REQ-020 StartE is ignored in DONE: the same instruction is still in Execute and leaves at the end of that cycle. A restart is possible from IDLE the following cycle.
REQ-021 Multiply: unsigned shift-add on operand magnitudes, then conditional 64-bit negate. Signedness per op: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU both unsigned.
REQ-022 Multiply result: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-023 Divide: restoring division on magnitudes. Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A). DIVU/REMU use unsigned operands.
REQ-024 Divide by zero (SrcBE=0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcAE. Latency is 1 cycle (IDLE -> DONE).
REQ-025 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0. Latency is 1 cycle.
REQ-026 FlushE=1 in any state: next state IDLE; the counter is cleared and no DoneE is issued. FlushE has priority over StartE.
REQ-027 Outputs other than DoneE/BusyE hold their last value in IDLE and RUN; the downstream stage qualifies them with DoneE.

Reset
REQ-028 reset=1 forces IDLE, counter=0, BusyE=0, DoneE=0, ResultE=0 and RdMDE=0 immediately, independent of clk.
REQ-029 Reset asserted mid-RUN aborts the operation with no DoneE. After deassertion the unit accepts a new StartE on the next edge.
REQ-030 Internal operand and accumulator registers are also cleared by reset.

Verification
REQ-031 MUL A=7, B=-3 (0xFFFFFFFD) -> BusyE high 33 cycles; DoneE on cycle 33; ResultE=0xFFFFFFEB; RdMDE=captured RdE.
REQ-032 MULHU A=B=0xFFFFFFFF -> ResultE=0xFFFFFFFE. MULH same operands -> ResultE=0x00000000.
REQ-033 DIV A=-7, B=2 -> ResultE=0xFFFFFFFD (-3). REM same operands -> ResultE=0xFFFFFFFF (-1). DIVU 100/7 -> 14.
REQ-034 DIV A=5, B=0 -> DoneE on the cycle after start, ResultE=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle.
REQ-035 FlushE pulsed at RUN count 10 -> BusyE drops next cycle, no DoneE. A new MUL 3*4 started immediately after returns 12 after 33 cycles.
REQ-036 reset asserted asynchronously mid-RUN (between edges) -> BusyE/DoneE/ResultE go to 0 before the next edge. StartE held high through DONE does not retrigger.
